// File: rtl/musk_bus_arbiter_pkg.sv
// rtl/musk_bus_arbiter_pkg.sv - shared types, widths and beat-count helpers for the MUSK bus arbiter
package musk_bus_arbiter_pkg;

    localparam int TAG_WIDTH          = 13;
    localparam int DATA_WIDTH         = 64;
    localparam int OWNER_WIDTH        = 8;
    localparam int CMD_WIDTH          = TAG_WIDTH - OWNER_WIDTH;
    localparam int IDX_WIDTH          = 3;
    localparam int LINE_BEATS_DEFAULT = 8;

    localparam logic [3:0] TYPE_MEMORY = 4'h2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP
    } arb_state_t;

    // rw=1 is a read; memory writes carry the header beat plus a full line
    function automatic logic [15:0] req_beat_count(input logic rw, input logic [3:0] typ,
                                                   input int line_beats);
        if (rw)
            return 16'd1;
        else if (typ == TYPE_MEMORY)
            return 16'(line_beats + 1);
        else
            return 16'd2;
    endfunction

    function automatic logic [15:0] resp_beat_count(input logic [3:0] typ, input int line_beats);
        return (typ == TYPE_MEMORY) ? 16'(line_beats) : 16'd1;
    endfunction

endpackage

// File: rtl/musk_bus_arbiter_picker.sv
// rtl/musk_bus_arbiter_picker.sv - combinational round-robin picker (module musk_rr_picker)
module musk_rr_picker
    import musk_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [IDX_WIDTH-1:0] last_i,
    output logic                 valid_o,
    output logic [IDX_WIDTH-1:0] idx_o
);

    // Walk the search order backwards so the candidate nearest last+1 is written last and wins
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if ((r == (int'(last_i) + 1 + k) % NUM_REQ) && req_i[r]) begin
                    valid_o = 1'b1;
                    idx_o   = IDX_WIDTH'(r);
                end
            end
        end
    end

endmodule

// File: rtl/musk_bus_arbiter.sv
// rtl/musk_bus_arbiter.sv - round-robin MUSK bus arbiter; define MUSK_ARB_WDT_EN for the response watchdog
module musk_bus_arbiter
    import musk_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int LINE_BEATS = LINE_BEATS_DEFAULT,
    parameter int TIMEOUT    = 1024
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_reqcyc,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]  req_reqtag,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_req,
    output logic [NUM_REQ-1:0]            req_reqack,
    output logic [NUM_REQ-1:0]            req_respcyc,
    output logic [DATA_WIDTH-1:0]         req_resp,
    input  logic [NUM_REQ-1:0]            req_respack,
    output logic                          bus_bid,
    output logic                          bus_reqcyc,
    output logic [TAG_WIDTH-1:0]          bus_reqtag,
    output logic [DATA_WIDTH-1:0]         bus_req,
    input  logic                          bus_reqack,
    input  logic                          bus_respcyc,
    input  logic [TAG_WIDTH-1:0]          bus_resptag,
    input  logic [DATA_WIDTH-1:0]         bus_resp,
    output logic                          bus_respack,
    output logic                          err
);

    arb_state_t           state_q;
    logic [IDX_WIDTH-1:0] owner_q, last_q;
    logic [15:0]          beat_q;
    logic                 rw_q, bid_q, err_q;
    logic [3:0]           type_q;

    logic                   pick_valid;
    logic [IDX_WIDTH-1:0]   pick_idx;
    logic [CMD_WIDTH-1:0]   pick_cmd, own_cmd;
    logic                   own_reqcyc, own_respack;
    logic [DATA_WIDTH-1:0]  own_req;
    logic [OWNER_WIDTH-1:0] owner_tag;
    logic                   tag_hit, req_xfer, resp_xfer, resp_drop;
    logic [15:0]            req_beats, resp_beats;
    logic                   unused_bits;

    musk_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req_i  (req_reqcyc),
        .last_i (last_q),
        .valid_o(pick_valid),
        .idx_o  (pick_idx)
    );

    always_comb begin
        own_reqcyc  = 1'b0;
        own_respack = 1'b0;
        own_cmd     = '0;
        own_req     = '0;
        pick_cmd    = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (owner_q == IDX_WIDTH'(r)) begin
                own_reqcyc  = req_reqcyc[r];
                own_respack = req_respack[r];
                own_cmd     = req_reqtag[r*TAG_WIDTH+OWNER_WIDTH +: CMD_WIDTH];
                own_req     = req_req[r*DATA_WIDTH +: DATA_WIDTH];
            end
            if (pick_idx == IDX_WIDTH'(r))
                pick_cmd = req_reqtag[r*TAG_WIDTH+OWNER_WIDTH +: CMD_WIDTH];
        end
    end

    assign owner_tag  = OWNER_WIDTH'(owner_q);
    assign tag_hit    = (bus_resptag[OWNER_WIDTH-1:0] == owner_tag);
    assign req_xfer   = (state_q == REQ) && own_reqcyc && bus_reqack;
    assign resp_xfer  = (state_q == RESP) && bus_respcyc && tag_hit && own_respack;
    assign resp_drop  = (state_q == RESP) && bus_respcyc && !tag_hit;
    assign req_beats  = req_beat_count(rw_q, type_q, LINE_BEATS);
    assign resp_beats = resp_beat_count(type_q, LINE_BEATS);

    // Only the low tag byte steers responses; the requester's low byte is overwritten
    assign unused_bits = ^{bus_resptag[TAG_WIDTH-1:OWNER_WIDTH], req_reqtag};

    always_comb begin
        bus_reqcyc  = 1'b0;
        bus_reqtag  = '0;
        bus_req     = '0;
        bus_respack = 1'b0;
        req_reqack  = '0;
        req_respcyc = '0;
        req_resp    = '0;
        if (state_q == REQ) begin
            bus_reqcyc = own_reqcyc;
            bus_reqtag = {own_cmd, owner_tag};
            bus_req    = own_req;
        end
        if ((state_q == RESP) && bus_respcyc) begin
            if (tag_hit) begin
                req_resp    = bus_resp;
                bus_respack = own_respack;
            end else begin
                bus_respack = 1'b1;
            end
        end
        for (int r = 0; r < NUM_REQ; r++) begin
            if (owner_q == IDX_WIDTH'(r)) begin
                req_reqack[r]  = (state_q == REQ) && bus_reqack;
                req_respcyc[r] = (state_q == RESP) && bus_respcyc && tag_hit;
            end
        end
    end

    assign bus_bid = bid_q;
    assign err     = err_q;

`ifdef MUSK_ARB_WDT_EN
    logic [31:0] wdt_q;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT > 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= '0;
            beat_q  <= '0;
            rw_q    <= 1'b0;
            type_q  <= '0;
            bid_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef MUSK_ARB_WDT_EN
            wdt_q   <= '0;
`endif
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        owner_q <= pick_idx;
                        last_q  <= pick_idx;
                        rw_q    <= pick_cmd[CMD_WIDTH-1];
                        type_q  <= pick_cmd[3:0];
                        beat_q  <= '0;
                        bid_q   <= 1'b1;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    if (req_xfer) begin
                        if (beat_q == req_beats - 16'd1) begin
                            beat_q <= '0;
`ifdef MUSK_ARB_WDT_EN
                            wdt_q  <= '0;
`endif
                            if (rw_q) begin
                                state_q <= RESP;
                            end else begin
                                state_q <= IDLE;
                                bid_q   <= 1'b0;
                            end
                        end else begin
                            beat_q <= beat_q + 16'd1;
                        end
                    end
                end
                RESP: begin
                    if (resp_drop)
                        err_q <= 1'b1;
                    if (resp_xfer) begin
`ifdef MUSK_ARB_WDT_EN
                        wdt_q <= '0;
`endif
                        if (beat_q == resp_beats - 16'd1) begin
                            beat_q  <= '0;
                            state_q <= IDLE;
                            bid_q   <= 1'b0;
                        end else begin
                            beat_q <= beat_q + 16'd1;
                        end
                    end
`ifdef MUSK_ARB_WDT_EN
                    else if (wdt_q == 32'(TIMEOUT - 1)) begin
                        wdt_q   <= '0;
                        beat_q  <= '0;
                        state_q <= IDLE;
                        bid_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        wdt_q <= wdt_q + 32'd1;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
